// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: INIT/RUN/DRAIN/HALT FSM with load-use stall, branch flush and perf counters.
// Optional overflow trap enabled by defining OVERFLOW_TRAP_EN.
module pipeline_sequencer #(
   parameter int STARTUP_CYCLES = 2,
   parameter int DRAIN_CYCLES   = 3,
   parameter int CNT_W          = 16
) (
   input  logic             clock,
   input  logic             resetGral,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_halt,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mem_read,
   input  logic             ex_valid,
   input  logic             branch_taken,
   input  logic             ALUOverflow,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             halted,
   output logic             exception,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       state_dbg
);

   // Encoding is visible on state_dbg: INIT=0, RUN=1, DRAIN=2, HALT=3.
   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] INIT_LAST  = 4'(STARTUP_CYCLES - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_t     state, next_state;
   logic [3:0] cyc_cnt;
   logic       hazard;
   logic       trap_req;
   logic       stall_inc, flush_inc, trap_take;

`ifdef OVERFLOW_TRAP_EN
   assign trap_req = ALUOverflow & ex_valid;
`else
   assign trap_req = 1'b0;
   logic unused_trap_inputs;
   assign unused_trap_inputs = &{1'b0, ALUOverflow, ex_valid};
`endif

   assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      next_state  = state;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      trap_take   = 1'b0;
      case (state)
         S_INIT: begin
            if (cyc_cnt == INIT_LAST) next_state = S_RUN;
         end
         S_RUN: begin
            if (trap_req) begin
               trap_take   = 1'b1;
               exmem_flush = 1'b1;
               ifid_flush  = 1'b1;
               next_state  = S_HALT;
            end else if (branch_taken) begin
               // Branch wins over a concurrent hazard or halt; the hazard source is being squashed.
               ifid_flush = 1'b1;
               pc_write   = 1'b1;
               flush_inc  = 1'b1;
            end else if (hazard) begin
               stall_inc = 1'b1;
            end else begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               idex_bubble = 1'b0;
               if (id_halt) next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (trap_req) begin
               trap_take   = 1'b1;
               exmem_flush = 1'b1;
               ifid_flush  = 1'b1;
               next_state  = S_HALT;
            end else if (cyc_cnt == DRAIN_LAST) begin
               next_state = S_HALT;
            end
         end
         default: ;
      endcase
      // Reset cycle presents the INIT outputs and ignores every input event.
      if (resetGral) begin
         next_state  = S_INIT;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b1;
         exmem_flush = 1'b0;
         stall_inc   = 1'b0;
         flush_inc   = 1'b0;
         trap_take   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (resetGral) begin
         state       <= S_INIT;
         cyc_cnt     <= 4'd0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state   <= next_state;
         cyc_cnt <= (next_state != state) ? 4'd0 : cyc_cnt + 4'd1;
         if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
         if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      end
   end

`ifdef OVERFLOW_TRAP_EN
   logic exception_q;
   always_ff @(posedge clock) begin
      if (resetGral)      exception_q <= 1'b0;
      else if (trap_take) exception_q <= 1'b1;
   end
   assign exception = exception_q;
`else
   logic unused_trap_take;
   assign unused_trap_take = trap_take;
   assign exception = 1'b0;
`endif

   assign halted    = (state == S_HALT) && !resetGral;
   assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: startup, stalls, branch priority, saturation, halt, trap, reset.
module tb_pipeline_sequencer;

   logic        clock = 1'b0;
   logic        resetGral;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_uses_rt, id_halt, ex_mem_read, ex_valid, branch_taken, ALUOverflow;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted, exception;
   logic [15:0] stall_count, flush_count;
   logic [1:0]  state_dbg;

   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_halted, s_exception;
   logic [3:0]  s_stall_count, s_flush_count;
   logic [1:0]  s_state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [1:0] ST_INIT = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_HALT = 2'd3;

   pipeline_sequencer dut (
      .clock(clock), .resetGral(resetGral), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
      .ex_valid(ex_valid), .branch_taken(branch_taken), .ALUOverflow(ALUOverflow),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .halted(halted),
      .exception(exception), .stall_count(stall_count), .flush_count(flush_count),
      .state_dbg(state_dbg)
   );

   pipeline_sequencer #(.CNT_W(4)) dut_sat (
      .clock(clock), .resetGral(resetGral), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
      .ex_valid(ex_valid), .branch_taken(branch_taken), .ALUOverflow(ALUOverflow),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush), .halted(s_halted),
      .exception(s_exception), .stall_count(s_stall_count), .flush_count(s_flush_count),
      .state_dbg(s_state_dbg)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_halt = 1'b0;
      ex_rt = 5'd0; ex_mem_read = 1'b0; ex_valid = 1'b0;
      branch_taken = 1'b0; ALUOverflow = 1'b0;
   endtask

   task automatic drive_hazard_rs(input logic [4:0] r);
      ex_mem_read = 1'b1; ex_rt = r; id_rs = r;
   endtask

   initial begin
      resetGral = 1'b1;
      idle_inputs();

      // reset held 3 cycles, with noisy inputs that must be ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         branch_taken = 1'b1; id_halt = 1'b1; drive_hazard_rs(5'd5);
         #1;
         check_eq("rst_pc_write", pc_write, 0);
         check_eq("rst_idex_bubble", idex_bubble, 1);
         check_eq("rst_ifid_flush", ifid_flush, 0);
         check_eq("rst_halted", halted, 0);
      end
      @(negedge clock);
      idle_inputs();
      resetGral = 1'b0;
      #1;
      check_eq("rst_state", state_dbg, ST_INIT);
      check_eq("rst_stall_count", stall_count, 0);
      check_eq("rst_flush_count", flush_count, 0);
      check_eq("rst_exception", exception, 0);
      check_eq("startup_c1_pc", pc_write, 0);
      @(negedge clock); #1;
      check_eq("startup_c2_pc", pc_write, 0);
      check_eq("startup_c2_bubble", idex_bubble, 1);
      @(negedge clock); #1;
      check_eq("startup_c3_pc", pc_write, 1);
      check_eq("startup_c3_ifid_write", ifid_write, 1);
      check_eq("startup_c3_bubble", idex_bubble, 0);
      check_eq("startup_c3_state", state_dbg, ST_RUN);

      // load-use via rs
      @(negedge clock);
      drive_hazard_rs(5'd5);
      #1;
      check_eq("stall_rs_pc", pc_write, 0);
      check_eq("stall_rs_ifid_write", ifid_write, 0);
      check_eq("stall_rs_bubble", idex_bubble, 1);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("stall_rs_release_pc", pc_write, 1);
      check_eq("stall_rs_release_bubble", idex_bubble, 0);
      check_eq("stall_rs_count", stall_count, 1);

      // ex_rt == 0 never stalls
      @(negedge clock);
      drive_hazard_rs(5'd0);
      #1;
      check_eq("no_stall_r0_pc", pc_write, 1);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("no_stall_r0_count", stall_count, 1);

      // rt only matters when the ID instruction reads rt
      @(negedge clock);
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
      #1;
      check_eq("rt_unused_pc", pc_write, 1);
      @(negedge clock);
      id_uses_rt = 1'b1;
      #1;
      check_eq("rt_used_pc", pc_write, 0);
      check_eq("rt_unused_count", stall_count, 1);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("rt_used_count", stall_count, 2);

      // branch + hazard + halt together: branch wins
      @(negedge clock);
      branch_taken = 1'b1; id_halt = 1'b1; drive_hazard_rs(5'd5);
      #1;
      check_eq("combo_ifid_flush", ifid_flush, 1);
      check_eq("combo_bubble", idex_bubble, 1);
      check_eq("combo_pc", pc_write, 1);
      check_eq("combo_ifid_write", ifid_write, 0);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("combo_flush_count", flush_count, 1);
      check_eq("combo_stall_count", stall_count, 2);
      check_eq("combo_state", state_dbg, ST_RUN);

      // 20 back-to-back stalls: 16-bit counter reaches 22, 4-bit counter stops at 15
      @(negedge clock);
      drive_hazard_rs(5'd9);
      repeat (20) @(negedge clock);
      idle_inputs();
      #1;
      check_eq("sat_wide_count", stall_count, 22);
      check_eq("sat_narrow_count", s_stall_count, 15);
      check_eq("sat_narrow_flush", s_flush_count, 1);

`ifndef OVERFLOW_TRAP_EN
      // overflow in RUN is ignored without the trap
      @(negedge clock);
      ALUOverflow = 1'b1; ex_valid = 1'b1;
      #1;
      check_eq("noTrap_run_exmem", exmem_flush, 0);
      check_eq("noTrap_run_pc", pc_write, 1);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("noTrap_run_state", state_dbg, ST_RUN);
      check_eq("noTrap_run_exception", exception, 0);
`endif

      // halt: DRAIN ignores branch/hazard
      @(negedge clock);
      id_halt = 1'b1;
      #1;
      check_eq("halt_req_pc", pc_write, 1);
      @(negedge clock);
      idle_inputs();
      branch_taken = 1'b1; drive_hazard_rs(5'd5);
      #1;
      check_eq("drain1_state", state_dbg, ST_DRAIN);
      check_eq("drain1_pc", pc_write, 0);
      check_eq("drain1_ifid_write", ifid_write, 0);
      check_eq("drain1_ifid_flush", ifid_flush, 0);
      check_eq("drain1_bubble", idex_bubble, 1);
      check_eq("drain1_halted", halted, 0);
      @(negedge clock);
      idle_inputs();
      ALUOverflow = 1'b1; ex_valid = 1'b1;
      #1;
      check_eq("drain2_state", state_dbg, ST_DRAIN);
      check_eq("drain_ignored_stall", stall_count, 22);
      check_eq("drain_ignored_flush", flush_count, 1);
`ifdef OVERFLOW_TRAP_EN
      check_eq("trap_exmem_flush", exmem_flush, 1);
      check_eq("trap_ifid_flush", ifid_flush, 1);
      check_eq("trap_pc", pc_write, 0);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("trap_state", state_dbg, ST_HALT);
      check_eq("trap_halted", halted, 1);
      check_eq("trap_exception", exception, 1);
`else
      check_eq("noTrap_exmem_flush", exmem_flush, 0);
      check_eq("noTrap_ifid_flush", ifid_flush, 0);
      @(negedge clock);
      idle_inputs();
      #1;
      check_eq("drain3_state", state_dbg, ST_DRAIN);
      check_eq("drain3_halted", halted, 0);
      check_eq("noTrap_exception", exception, 0);
      @(negedge clock); #1;
      check_eq("halt_state", state_dbg, ST_HALT);
`endif

      // HALT holds for 10 cycles regardless of inputs
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         branch_taken = i[0]; id_halt = 1'b1;
         #1;
         check_eq("halt_hold_halted", halted, 1);
         check_eq("halt_hold_pc", pc_write, 0);
         check_eq("halt_hold_ifid_flush", ifid_flush, 0);
         check_eq("halt_hold_bubble", idex_bubble, 1);
      end

      // reset out of HALT
      @(negedge clock);
      idle_inputs();
      resetGral = 1'b1;
      #1;
      check_eq("halt_rst_halted_now", halted, 0);
      @(negedge clock);
      resetGral = 1'b0;
      #1;
      check_eq("halt_rst_state", state_dbg, ST_INIT);
      check_eq("halt_rst_halted", halted, 0);
      check_eq("halt_rst_stall", stall_count, 0);
      check_eq("halt_rst_flush", flush_count, 0);
      check_eq("halt_rst_sat_stall", s_stall_count, 0);
      check_eq("halt_rst_exception", exception, 0);
      check_eq("restart_c1_pc", pc_write, 0);
      @(negedge clock); #1;
      check_eq("restart_c2_pc", pc_write, 0);
      @(negedge clock); #1;
      check_eq("restart_c3_pc", pc_write, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter STARTUP_CYCLES, default 2: idle cycles after reset release before fetch starts (range 1..15).
REQ-002 Parameter DRAIN_CYCLES, default 3: bubble cycles inserted after a halt before HALT is entered (range 1..7).
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 resetGral  in  1  synchronous, active-high reset.
REQ-006 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-007 id_uses_rt  in  1  ID instruction reads rt.
REQ-008 id_halt  in  1  ID holds a halt instruction.
REQ-009 ex_rt  in  5  destination register of the instruction in EX.
REQ-010 ex_mem_read  in  1  EX instruction is a load.
REQ-011 ex_valid  in  1  EX holds a real instruction, not a bubble.
REQ-012 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-013 ALUOverflow  in  1  datapath ALU overflow flag for the EX instruction.
REQ-014 pc_write, ifid_write  out  1 each  PC and IF/ID register update enables.
REQ-015 ifid_flush, idex_bubble, exmem_flush  out  1 each  squash IF/ID, insert an ID/EX bubble, squash EX/MEM.
REQ-016 halted, exception  out  1 each  the sequencer is in HALT; sticky overflow trap flag.
REQ-017 stall_count, flush_count  out  CNT_W each  saturating counts of load-use stalls and branch flushes.

Function
REQ-018 The state machine SHALL have four states: INIT, RUN, DRAIN and HALT. Control outputs SHALL be combinational from the state and the current inputs (Mealy).
REQ-019 INIT: every enable SHALL be 0 and idex_bubble SHALL be 1. After STARTUP_CYCLES cycles in INIT, the state SHALL move to RUN.
REQ-020 RUN, no event: pc_write=1, ifid_write=1, and every flush/bubble output SHALL be 0.
REQ-021 Load-use hazard in RUN:
- Condition: ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Response in the same cycle: pc_write=0, ifid_write=0, idex_bubble=1.
- stall_count SHALL increment by 1.
REQ-022 branch_taken in RUN:
- Response: ifid_flush=1, idex_bubble=1, pc_write=1.
- flush_count SHALL increment by 1.
- Takes priority over a simultaneous load-use hazard; no stall is counted that cycle.
REQ-023 id_halt in RUN, with no branch_taken and no hazard: the state SHALL move to DRAIN. If branch_taken is also high, id_halt SHALL be ignored.
REQ-024 DRAIN:
- Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
- After DRAIN_CYCLES cycles, the state SHALL move to HALT.
- branch_taken and hazards SHALL be ignored.
REQ-025 HALT: all enables 0, idex_bubble=1, halted=1. The state SHALL remain HALT until reset.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 The INIT and DRAIN cycle counters SHALL reset to 0 on entry to their state.

Reset
REQ-028 While resetGral=1 at a rising edge, the following SHALL take effect on that edge, including mid-DRAIN or in HALT:
- state becomes INIT;
- all counters and exception become 0;
- outputs are pc_write=0, ifid_write=0, ifid_flush=0, exmem_flush=0, idex_bubble=1, halted=0.
REQ-029 Input events on a reset cycle SHALL be ignored.

Configuration
REQ-030 With macro OVERFLOW_TRAP_EN defined, ALUOverflow & ex_valid in RUN or DRAIN SHALL trap:
- In the same cycle: exmem_flush=1, ifid_flush=1, idex_bubble=1, pc_write=0, ifid_write=0.
- exception SHALL be set and stay set.
- The next state SHALL be HALT.
- The trap has the highest priority over every other event.
REQ-031 Without OVERFLOW_TRAP_EN, ALUOverflow SHALL be ignored, exmem_flush SHALL be tied to 0, and exception SHALL be tied to 0.

Verification
REQ-032 Startup: reset for 3 cycles, then release -> pc_write=0 for exactly 2 cycles, then pc_write=1 on the 3rd cycle.
REQ-033 Load-use stall: in RUN, ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0 and idex_bubble=1 that cycle only, and stall_count=1. Repeating with ex_rt=0 -> no stall.
REQ-034 Simultaneous events: branch_taken=1 together with the REQ-033 hazard and id_halt=1 -> ifid_flush=1, flush_count=1, stall_count unchanged, state stays RUN.
REQ-035 Halt:
- Stimulus: id_halt=1 in RUN.
- Response: 3 DRAIN cycles, then halted=1, held for 10 cycles.
- Then resetGral=1 -> halted=0 on the next edge and state INIT.
REQ-036 Trap:
- Stimulus: with OVERFLOW_TRAP_EN, ALUOverflow=1 and ex_valid=1 during DRAIN.
- Response: exmem_flush=1 that cycle, then halted=1 and exception=1.
- Without the macro: no response, and DRAIN completes normally.
REQ-037 Saturation: with CNT_W=4, apply 20 load-use stalls -> stall_count=15.
